// File: rtl/wb_spi_bridge_host.sv
// Wishbone B4 classic slave that turns each single-byte bus cycle into one SPI mode-0 frame.
// Optional feature: define WB_SPI_HOST_ABORT_EN to abandon a frame when cyc_i drops mid-transfer.
module wb_spi_bridge_host #(
  parameter int ADDR_WIDTH      = 23,
  parameter int CLK_DIV         = 2,
  parameter int READ_DUMMY_BITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic                  we_i,
  input  logic [7:0]            dat_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  rty_o,
  output logic [7:0]            dat_o,
  output logic                  spi_ss_n,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int W_BITS = ADDR_WIDTH + 9;
  localparam int R_BITS = ADDR_WIDTH + 9 + READ_DUMMY_BITS;
  localparam int SH_W   = R_BITS;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W  = $clog2(R_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(W_BITS - 1);
  localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(R_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SHIFT,
    S_HOLD,
    S_DESELECT,
    S_ACK
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic             half_q, half_d;
  logic [SH_W-1:0]  shreg_q, shreg_d;
  logic [7:0]       rx_q, rx_d;
  logic             is_rd_q, is_rd_d;
  logic             aborted_q, aborted_d;
  logic [7:0]       dat_q, dat_d;
  logic             sck_q, sck_d;
  logic             ss_n_q, ss_n_d;
  logic             mosi_q, mosi_d;

  logic [SH_W-1:0]  wr_load;
  logic [SH_W-1:0]  rd_load;
  logic [CNT_W-1:0] last_bit;
  logic             div_done;

  // Frames are left-aligned so the MSB of the shift register is always the next MOSI bit.
  assign wr_load  = SH_W'({we_i, adr_i, dat_i}) << READ_DUMMY_BITS;
  assign rd_load  = SH_W'({we_i, adr_i}) << (8 + READ_DUMMY_BITS);
  assign last_bit = is_rd_q ? R_LAST : W_LAST;
  assign div_done = (div_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      half_q    <= 1'b0;
      shreg_q   <= '0;
      rx_q      <= '0;
      is_rd_q   <= 1'b0;
      aborted_q <= 1'b0;
      dat_q     <= '0;
      sck_q     <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      half_q    <= half_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      is_rd_q   <= is_rd_d;
      aborted_q <= aborted_d;
      dat_q     <= dat_d;
      sck_q     <= sck_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    half_d    = half_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    is_rd_d   = is_rd_q;
    aborted_d = aborted_q;
    dat_d     = dat_q;
    sck_d     = sck_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;

    case (state_q)
      S_IDLE: begin
        sck_d     = 1'b0;
        ss_n_d    = 1'b1;
        mosi_d    = 1'b0;
        aborted_d = 1'b0;
        if (cyc_i && stb_i) begin
          state_d = S_SELECT;
          div_d   = DIV_MAX;
          is_rd_d = !we_i;
          shreg_d = we_i ? wr_load : rd_load;
          ss_n_d  = 1'b0;
          mosi_d  = we_i;
        end
      end
      S_SELECT: begin
        if (div_done) begin
          state_d = S_SHIFT;
          div_d   = DIV_MAX;
          bit_d   = '0;
          half_d  = 1'b0;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_done) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIV_MAX;
          if (!half_q) begin
            half_d = 1'b1;
            sck_d  = 1'b1;
          end else begin
            // Last clock of the high half: sample MISO, then drop SCK and advance MOSI together.
            rx_d   = {rx_q[6:0], spi_miso};
            half_d = 1'b0;
            sck_d  = 1'b0;
            if (bit_q == last_bit) begin
              state_d = S_HOLD;
              mosi_d  = 1'b0;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shreg_q << 1;
              mosi_d  = shreg_q[SH_W-2];
            end
          end
        end
      end
      S_HOLD: begin
        if (div_done) begin
          state_d = S_DESELECT;
          div_d   = DIV_MAX;
          ss_n_d  = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_DESELECT: begin
        if (div_done) begin
          if (aborted_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ACK;
            if (is_rd_q) dat_d = rx_q;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef WB_SPI_HOST_ABORT_EN
    if (!cyc_i && (state_q == S_SELECT || state_q == S_SHIFT || state_q == S_HOLD)) begin
      state_d   = S_DESELECT;
      div_d     = DIV_MAX;
      sck_d     = 1'b0;
      ss_n_d    = 1'b1;
      mosi_d    = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  // A master that dropped cyc_i before the end of the frame is not acknowledged.
  assign ack_o    = (state_q == S_ACK) && cyc_i;
  assign err_o    = 1'b0;
  assign rty_o    = 1'b0;
  assign dat_o    = dat_q;
  assign spi_sck  = sck_q;
  assign spi_ss_n = ss_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_wb_spi_bridge_host.sv
// Directed bench for wb_spi_bridge_host: default instance plus a CLK_DIV=1 instance, with a small SPI slave model.
module tb_wb_spi_bridge_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, stb, we, sel, miso;
  logic [22:0] adr;
  logic [7:0]  dat;

  logic        cyc0, stb0, cyc1, stb1;
  logic        ack0, err0, rty0, ss0, sck0, mosi0;
  logic        ack1, err1, rty1, ss1, sck1, mosi1;
  logic [7:0]  dout0, dout1;

  logic        o_ack, o_ss_n, o_sck, o_mosi;
  logic [7:0]  o_dat;

  assign cyc0   = cyc & ~sel;
  assign stb0   = stb & ~sel;
  assign cyc1   = cyc & sel;
  assign stb1   = stb & sel;
  assign o_ack  = sel ? ack1  : ack0;
  assign o_ss_n = sel ? ss1   : ss0;
  assign o_sck  = sel ? sck1  : sck0;
  assign o_mosi = sel ? mosi1 : mosi0;
  assign o_dat  = sel ? dout1 : dout0;

  wb_spi_bridge_host dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc0), .stb_i(stb0), .adr_i(adr), .we_i(we),
    .dat_i(dat), .ack_o(ack0), .err_o(err0), .rty_o(rty0), .dat_o(dout0),
    .spi_ss_n(ss0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso)
  );

  wb_spi_bridge_host #(.CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc1), .stb_i(stb1), .adr_i(adr), .we_i(we),
    .dat_i(dat), .ack_o(ack1), .err_o(err1), .rty_o(rty1), .dat_o(dout1),
    .spi_ss_n(ss1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Length of the most recent run of ss_n-high cycles that ended in a frame start.
  int hi_run   = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (o_ss_n) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  // One bus cycle; k counts cycles from the edge that samples the request (k=0 is that cycle).
  task automatic run(input logic t_we, input logic [22:0] t_adr, input logic [7:0] t_dat,
                     input logic [7:0] t_rx, input int drop_at, input int rst_at,
                     output int ack_cyc, output int pulses, output logic [63:0] cap,
                     output logic [7:0] rd, output logic ss_after, output logic sck_after);
    logic prev;
    int   ev;
    int   j;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; dat = t_dat; miso = 1'b0;
    prev = 1'b0; ack_cyc = -1; pulses = 0; cap = '0; rd = '0;
    ss_after = 1'b0; sck_after = 1'b1; ev = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ev >= 0 && k == ev + 1) begin
        ss_after  = o_ss_n;
        sck_after = o_sck;
        rst       = 1'b0;
      end
      if (o_sck && !prev) begin
        cap = {cap[62:0], o_mosi};
        pulses++;
        j = 39 - (pulses - 1);
        if (j >= 0 && j <= 7) miso = t_rx[j];
        else miso = 1'b0;
        if (pulses == drop_at) begin cyc = 1'b0; stb = 1'b0; ev = k; end
        if (pulses == rst_at)  begin rst = 1'b1; cyc = 1'b0; stb = 1'b0; ev = k; end
      end
      prev = o_sck;
      if (o_ack && ack_cyc < 0) begin
        ack_cyc = k;
        rd = o_dat;
        cyc = 1'b0; stb = 1'b0;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [22:0] adr;
    logic [7:0]  dat;
    logic [7:0]  rx;
    int          ack;
    int          pulses;
    logic [63:0] cap;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs[8];

  int          a_cyc, n_p;
  logic [63:0] c;
  logic [7:0]  r;
  logic        ssa, scka;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 23'h000005, 8'hA5, 8'h00, 134, 32, 64'h800005A5,   8'h00};
    vecs[1] = '{1'b0, 1'b0, 23'h400010, 8'h00, 8'h3C, 166, 40, 64'h4000100000, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 23'h7FFFFF, 8'h00, 8'h00, 134, 32, 64'hFFFFFF00,   8'h3C};
    vecs[3] = '{1'b0, 1'b0, 23'h000000, 8'h00, 8'hFF, 166, 40, 64'h0,          8'hFF};
    vecs[4] = '{1'b0, 1'b0, 23'h2AAAAA, 8'h00, 8'h81, 166, 40, 64'h2AAAAA0000, 8'h81};
    vecs[5] = '{1'b1, 1'b1, 23'h000005, 8'hA5, 8'h00, 67,  32, 64'h800005A5,   8'h00};
    vecs[6] = '{1'b1, 1'b1, 23'h123456, 8'h5A, 8'h00, 67,  32, 64'h9234565A,   8'h00};
    vecs[7] = '{1'b1, 1'b0, 23'h000001, 8'h00, 8'hC3, 83,  40, 64'h0000010000, 8'hC3};

    sel = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; miso = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_ss_n", ss0, 1'b1);
    check("reset_sck",  sck0, 1'b0);
    check("reset_mosi", mosi0, 1'b0);
    check("reset_ack",  ack0, 1'b0);
    check("reset_dat_o", dout0, 8'h00);
    check("err_rty_tied", {err0, rty0, err1, rty1}, 4'h0);

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      run(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].rx, 0, 0, a_cyc, n_p, c, r, ssa, scka);
      check($sformatf("v%0d_ack_cycle", i), a_cyc, vecs[i].ack);
      check($sformatf("v%0d_sck_pulses", i), n_p, vecs[i].pulses);
      check($sformatf("v%0d_mosi", i), c, vecs[i].cap);
      check($sformatf("v%0d_dat_o", i), r, vecs[i].rd);
      if (i == 6) check("b2b_ss_gap_ge2", (last_gap >= 2), 1'b1);
    end

    // Reset at bit 10 of a read: frame dropped, outputs idle on the next edge.
    sel = 1'b0;
    run(1'b0, 23'h400010, 8'h00, 8'h3C, 0, 10, a_cyc, n_p, c, r, ssa, scka);
    check("rst_mid_no_ack", a_cyc, -1);
    check("rst_mid_ss_n", ssa, 1'b1);
    check("rst_mid_sck", scka, 1'b0);
    check("rst_mid_pulses", n_p, 10);
    check("rst_mid_dat_o", dout0, 8'h00);
    run(1'b1, 23'h000005, 8'hA5, 8'h00, 0, 0, a_cyc, n_p, c, r, ssa, scka);
    check("post_rst_ack_cycle", a_cyc, 134);
    check("post_rst_mosi", c, 64'h800005A5);
    check("post_rst_pulses", n_p, 32);

    // cyc_i dropped at bit 5 of a write.
    run(1'b1, 23'h000005, 8'hA5, 8'h00, 5, 0, a_cyc, n_p, c, r, ssa, scka);
    check("drop_no_ack", a_cyc, -1);
`ifdef WB_SPI_HOST_ABORT_EN
    check("drop_ss_n_rises", ssa, 1'b1);
    check("drop_sck_low", scka, 1'b0);
    check("drop_pulses_lt6", (n_p < 6), 1'b1);
`else
    check("drop_pulses", n_p, 32);
    check("drop_mosi", c, 64'h800005A5);
`endif
    check("drop_dat_o", dout0, 8'h00);
    repeat (5) @(negedge clk);
    check("drop_idle_ss_n", ss0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
